// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss path: FSM states, address field
// widths, the line alignment helper and the memory request bundle.
package cache_pkg;

  localparam int TAG_W       = 18;
  localparam int INDEX_W     = 8;
  localparam int OFFSET_W    = 6;
  localparam int LINE_ADDR_W = TAG_W + INDEX_W + OFFSET_W;
  localparam int LINE_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    FILL_REQ,
    RESP,
    COOL
  } miss_state_t;

  typedef struct packed {
    logic                   we;
    logic [LINE_ADDR_W-1:0] addr;
    logic [LINE_DATA_W-1:0] wdata;
  } mem_req_t;

  // Clears the byte-offset bits so the address points at the start of a line.
  function automatic logic [LINE_ADDR_W-1:0] line_addr(input logic [LINE_ADDR_W-1:0] addr,
                                                       input int offset_w);
    logic [LINE_ADDR_W-1:0] mask;
    mask = {LINE_ADDR_W{1'b1}} << offset_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/mem_req_port.sv
// Registered req/ack holder toward backing memory. One request is launched by
// 'start' and held stable until an ack (or a timeout) retires it. The timeout
// counter exists only when MEM_TIMEOUT_EN is defined.
module mem_req_port
  import cache_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  mem_req_t               req,
  input  logic                   mem_ack,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [LINE_ADDR_W-1:0] mem_addr,
  output logic [LINE_DATA_W-1:0] mem_wdata,
  output logic                   done,
  output logic                   timeout
);

  // An ack only counts while a request is actually outstanding.
  assign done = mem_req && mem_ack;

  // Launch, hold and retire the memory request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= req.we;
      mem_addr  <= req.addr;
      mem_wdata <= req.wdata;
    end else if (done || timeout) begin
      mem_req   <= 1'b0;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout = mem_req && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Count request cycles that go by without an ack; restart on every launch.
  always_ff @(posedge clk) begin
    if (!rst || start) begin
      wait_cnt <= '0;
    end else if (mem_req && !mem_ack && !timeout) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  // Without the timeout the FSM waits for ack indefinitely; the parameter is
  // kept referenced so both builds share one interface.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss/eviction handler behind sa_cache: optional dirty-line write-back, then a
// line fill, then a one-cycle response carrying the fill data back to the cache.
// Optional feature: define MEM_TIMEOUT_EN to bound each memory wait.
module cache_miss_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int OFFSET_W       = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cache_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              i_evict,
  input  logic [ADDR_W-1:0] i_evict_addr,
  input  logic [DATA_W-1:0] i_evict_data,
  output logic [DATA_W-1:0] o_memory_line,
  output logic              o_memory_response,
  output logic              o_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              o_mem_err
);
  import cache_pkg::*;

  miss_state_t state_q, state_d;
  mem_req_t    wb_req, fill_req, port_req;
  logic        start, done, timeout;

  // The single memory port serves the write-back first, then the fill.
  assign port_req = (state_q == WB_REQ) ? wb_req : fill_req;

  mem_req_port #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_port (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .req      (port_req),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .done     (done),
    .timeout  (timeout)
  );

  // Next-state logic; a request launches on the first cycle of each request state.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE:     if (i_cache_miss) state_d = i_evict ? WB_REQ : FILL_REQ;
      WB_REQ: begin
        start = !mem_req;
        if (timeout)   state_d = RESP;
        else if (done) state_d = FILL_REQ;
      end
      FILL_REQ: begin
        start = !mem_req;
        if (done || timeout) state_d = RESP;
      end
      RESP:     state_d = COOL;
      COOL:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State, captured miss/victim info and registered cache-side outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= IDLE;
      wb_req            <= '0;
      fill_req          <= '0;
      o_memory_line     <= '0;
      o_memory_response <= 1'b0;
      o_busy            <= 1'b0;
      o_mem_err         <= 1'b0;
    end else begin
      state_q           <= state_d;
      o_busy            <= (state_d != IDLE);
      o_memory_response <= (state_d == RESP);
`ifdef MEM_TIMEOUT_EN
      o_mem_err         <= timeout;
`else
      o_mem_err         <= 1'b0;
`endif
      if (state_q == IDLE && i_cache_miss) begin
        wb_req   <= '{we: i_evict, addr: line_addr(i_evict_addr, OFFSET_W), wdata: i_evict_data};
        fill_req <= '{we: 1'b0, addr: line_addr(i_miss_addr, OFFSET_W), wdata: '0};
      end
      if (timeout) begin
        o_memory_line <= '0;
      end else if (state_q == FILL_REQ && done) begin
        o_memory_line <= mem_rdata;
      end
    end
  end

endmodule
